// File: rtl/pm_uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// pm_uart_loader_pkg
// Shared constants for the program-memory UART loader:
//   c_ldr_sync      - sync byte that opens every image frame
//   S_*             - loader FSM state encoding (4-bit)
//   RX_*            - UART receiver state encoding (2-bit)
//   clog2()         - counter width helper (never returns less than 1)
// -----------------------------------------------------------------------------
package pm_uart_loader_pkg;

    localparam logic [7:0] c_ldr_sync = 8'hA5;

    // Loader FSM states
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CNT_L = 4'd1;
    localparam logic [3:0] S_CNT_H = 4'd2;
    localparam logic [3:0] S_DAT_L = 4'd3;
    localparam logic [3:0] S_DAT_H = 4'd4;
    localparam logic [3:0] S_CSUM  = 4'd5;
    localparam logic [3:0] S_DONE  = 4'd6;
    localparam logic [3:0] S_ERR   = 4'd7;

    // UART receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Bits needed to hold values 0..value-1; at least 1.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pm_uart_loader_if.sv
// -----------------------------------------------------------------------------
// pm_uart_loader_if
// Program-memory write port driven by the loader toward p_mem.
//   pm_adr   - word address
//   pm_dout  - write data {high byte, low byte}
//   pm_we_h  - high byte write strobe
//   pm_we_l  - low byte write strobe
//   pm_ce    - chip enable
// Modports: master (loader side, drives), slave (memory side, receives).
// -----------------------------------------------------------------------------
interface pm_uart_loader_if;

    logic [15:0] pm_adr;
    logic [15:0] pm_dout;
    logic        pm_we_h;
    logic        pm_we_l;
    logic        pm_ce;

    modport master (
        output pm_adr,
        output pm_dout,
        output pm_we_h,
        output pm_we_l,
        output pm_ce
    );

    modport slave (
        input pm_adr,
        input pm_dout,
        input pm_we_h,
        input pm_we_l,
        input pm_ce
    );

endinterface

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Ports:
//   clk      - system clock
//   nrst     - asynchronous active-low reset
//   rxd      - serial input, idle high, asynchronous to clk
//   rx_byte  - last received byte (valid while rx_vld is high)
//   rx_vld   - 1-cycle pulse: byte received with a good stop bit
//   rx_ferr  - 1-cycle pulse: stop bit sampled low
// Parameter clk_div: clock cycles per bit (8..65535).
// -----------------------------------------------------------------------------
module uart_rx_byte
    import pm_uart_loader_pkg::*;
#(
    parameter int clk_div = 434
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_ferr
);

    localparam int            CW        = clog2(clk_div);
    localparam logic [CW-1:0] c_bit_end = CW'(clk_div - 1);
    localparam logic [CW-1:0] c_half    = CW'(clk_div / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    // Synchronizer and edge-history flops reset to the idle-high level so
    // that leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            prev_q <= sync_q[1];
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) begin
                    st_d = RX_START;
                end
            end
            RX_START: begin
                // Half-bit re-check rejects short low glitches.
                if (cnt_q == c_half) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    st_d  = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == c_bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        st_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Returning to idle at mid-stop leaves half a bit to re-arm
                // for a back-to-back start edge.
                if (cnt_q == c_bit_end) begin
                    cnt_d  = '0;
                    st_d   = RX_IDLE;
                    vld_d  = rx_s;
                    ferr_d = !rx_s;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte = shift_q;
    assign rx_vld  = vld_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/pm_uart_loader.sv
// -----------------------------------------------------------------------------
// pm_uart_loader
// Boot-time loader: receives an AVR image over UART and writes it into
// program memory, holding the core in reset while loading.
// Frame: A5, count lo, count hi, N x (data lo, data hi), checksum (8-bit sum
// of data bytes).
// Ports:
//   clk, nrst   - clock, asynchronous active-low reset
//   en          - loader enable; low forces IDLE and clears status
//   rxd         - UART input, 8N1
//   pm          - program-memory write port (master)
//   core_rst_n  - core reset request, active-low
//   busy        - load in progress
//   done / err  - sticky result of the last load
// -----------------------------------------------------------------------------
module pm_uart_loader
    import pm_uart_loader_pkg::*;
#(
    parameter int clk_div = 434,
    parameter int pm_size = 8,
    parameter int tmo_cyc = 1000000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic               rxd,
    pm_uart_loader_if.master   pm,
    output logic               core_rst_n,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int            TW          = clog2(tmo_cyc);
    localparam logic [TW-1:0] c_tmo_end   = TW'(tmo_cyc - 1);
    localparam logic [16:0]   c_max_words = 17'(pm_size * 1024);

    logic [7:0]    rx_byte;
    logic          rx_vld;
    logic          rx_ferr;

    logic [3:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   dout_q, dout_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          crst_q, crst_d;

    logic          busy_state;
    logic          sync_hit;
    logic          tmo_hit;
    logic          last_word;

    uart_rx_byte #(.clk_div(clk_div)) u_rx (
        .clk     (clk),
        .nrst    (nrst),
        .rxd     (rxd),
        .rx_byte (rx_byte),
        .rx_vld  (rx_vld),
        .rx_ferr (rx_ferr)
    );

    assign busy_state = (state_q >= S_CNT_L) && (state_q <= S_CSUM);
    assign sync_hit   = rx_vld && !busy_state && (rx_byte == c_ldr_sync);
    assign tmo_hit    = busy_state && (tmo_q == c_tmo_end);
    assign last_word  = (addr_q + 16'd1) == cnt_q;

    // FSM: state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Priority is en, then frame error, then a received
    // byte, then timeout (a byte landing on the last idle cycle still counts).
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else if (rx_ferr && busy_state) begin
            state_d = S_ERR;
        end else if (rx_vld) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (sync_hit) state_d = S_CNT_L;
                S_CNT_L: state_d = S_CNT_H;
                S_CNT_H: begin
                    if ({1'b0, rx_byte, cnt_q[7:0]} > c_max_words) begin
                        state_d = S_ERR;
                    end else if ({rx_byte, cnt_q[7:0]} == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DAT_L;
                    end
                end
                S_DAT_L: state_d = S_DAT_H;
                S_DAT_H: state_d = last_word ? S_CSUM : S_DAT_L;
                S_CSUM:  state_d = (rx_byte == sum_q) ? S_DONE : S_ERR;
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = S_ERR;
        end
    end

    // FSM: outputs, decoded from the next state so they register alongside it
    always_comb begin
        busy_d = (state_d >= S_CNT_L) && (state_d <= S_CSUM);
        crst_d = (state_d == S_IDLE) || (state_d == S_DONE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        we_d   = en && rx_vld && (state_q == S_DAT_H);
    end

    // Datapath: count, address, data, checksum, timeout
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        dout_d = dout_q;
        lo_d   = lo_q;
        sum_d  = sum_q;
        tmo_d  = busy_state ? tmo_q + 1'b1 : '0;
        if (we_q) begin
            addr_d = addr_q + 16'd1;
        end
        if (en) begin
            if (rx_vld) begin
                // Reload to 1: the cycle after a byte is the first idle one.
                tmo_d = TW'(1);
                case (state_q)
                    S_CNT_L: cnt_d[7:0]  = rx_byte;
                    S_CNT_H: cnt_d[15:8] = rx_byte;
                    S_DAT_L: begin
                        lo_d  = rx_byte;
                        sum_d = sum_q + rx_byte;
                    end
                    S_DAT_H: begin
                        dout_d = {rx_byte, lo_q};
                        sum_d  = sum_q + rx_byte;
                    end
                    default: ;
                endcase
            end
            if (sync_hit) begin
                addr_d = 16'd0;
                sum_d  = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= 16'd0;
            addr_q <= 16'd0;
            dout_q <= 16'd0;
            lo_q   <= 8'd0;
            sum_q  <= 8'd0;
            tmo_q  <= '0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            crst_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            dout_q <= dout_d;
            lo_q   <= lo_d;
            sum_q  <= sum_d;
            tmo_q  <= tmo_d;
            we_q   <= we_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
            crst_q <= crst_d;
        end
    end

    assign pm.pm_adr  = addr_q;
    assign pm.pm_dout = dout_q;
    assign pm.pm_we_h = we_q;
    assign pm.pm_we_l = we_q;
    assign pm.pm_ce   = we_q;

    assign core_rst_n = crst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pm_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_pm_uart_loader
// Directed bench for pm_uart_loader (clk_div=16, pm_size=1, tmo_cyc=200).
// -----------------------------------------------------------------------------
module tb_pm_uart_loader;

    localparam int CLK_DIV = 16;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic en   = 1'b1;
    logic rxd  = 1'b1;
    logic core_rst_n, busy, done, err;

    pm_uart_loader_if pm_bus ();

    pm_uart_loader #(
        .clk_div (CLK_DIV),
        .pm_size (1),
        .tmo_cyc (200)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .rxd        (rxd),
        .pm         (pm_bus),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          wr_cyc   = 0;
    int          wait_n;
    logic [15:0] wr_adr[$];
    logic [15:0] wr_dat[$];
    logic [7:0]  tx[$];
    logic [15:0] exp_dat[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must come as the full ce/we_h/we_l triple.
    always @(negedge clk) begin
        if (pm_bus.pm_ce || pm_bus.pm_we_h || pm_bus.pm_we_l) begin
            check("strobe_set", {29'd0, pm_bus.pm_ce, pm_bus.pm_we_h, pm_bus.pm_we_l}, 32'd7);
            wr_adr.push_back(pm_bus.pm_adr);
            wr_dat.push_back(pm_bus.pm_dout);
            wr_cyc = cyc;
            $display("write adr=%04h dat=%04h", pm_bus.pm_adr, pm_bus.pm_dout);
        end
    end

    // Called at a negedge; returns at a negedge with the stop bit complete.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_tx(input string name);
        foreach (tx[i]) send_byte(tx[i], 1'b1);
        repeat (4) @(negedge clk);
        $display("frame %s: %0d bytes, writes=%0d done=%b err=%b busy=%b core_rst_n=%b",
                 name, tx.size(), wr_adr.size(), done, err, busy, core_rst_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_dat = '{16'h2211, 16'h4433, 16'h6655};

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ce", pm_bus.pm_ce, 0);
        check("rst_adr", pm_bus.pm_adr, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_release_core_rst_n", core_rst_n, 1);
        repeat (4) @(negedge clk);

        // ---------------- nominal load ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5};
        send_tx("nominal_sync");
        check("nom_busy", busy, 1);
        check("nom_core_rst_low", core_rst_n, 0);
        // checksum 11+22+33+44+55+66 = 0x165 -> 0x65
        tx = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
        send_tx("nominal_body");
        check("nom_nwr", wr_adr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wr_adr.size()) begin
                check("nom_adr", wr_adr[i], i);
                check("nom_dat", wr_dat[i], exp_dat[i]);
            end
        end
        check("nom_done", done, 1);
        check("nom_err", err, 0);
        check("nom_busy_end", busy, 0);
        check("nom_core_rst_n", core_rst_n, 1);

        // ---------------- bad checksum ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'h55, 8'h00};
        send_tx("bad_csum");
        check("bad_nwr", wr_adr.size(), 1);
        if (wr_adr.size() > 0) begin
            check("bad_adr", wr_adr[0], 0);
            check("bad_dat", wr_dat[0], 16'h55AA);
        end
        check("bad_err", err, 1);
        check("bad_done", done, 0);
        check("bad_core_rst_n", core_rst_n, 0);

        // ---------------- glitch and garbage in ERR ----------------
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_err", err, 1);
        check("glitch_busy", busy, 0);
        tx = '{8'h00, 8'hFF};
        send_tx("garbage");
        check("garbage_err", err, 1);
        check("garbage_busy", busy, 0);

        // ---------------- empty count ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_tx("empty");
        check("empty_done", done, 1);
        check("empty_err", err, 0);
        check("empty_nwr", wr_adr.size(), 0);
        check("empty_core_rst_n", core_rst_n, 1);

        // ---------------- oversize count (1025 > 1024) ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5, 8'h01, 8'h04};
        send_tx("oversize");
        check("over_err", err, 1);
        check("over_done", done, 0);
        check("over_nwr", wr_adr.size(), 0);
        check("over_core_rst_n", core_rst_n, 0);

        // ---------------- frame error during DAT_H ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h11};
        send_tx("ferr_head");
        check("ferr_busy", busy, 1);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr_err", err, 1);
        check("ferr_nwr", wr_adr.size(), 0);
        check("ferr_busy_end", busy, 0);

        // ---------------- inter-byte timeout ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        send_tx("timeout");
        check("tmo_nwr", wr_adr.size(), 1);
        if (wr_dat.size() > 0) check("tmo_dat", wr_dat[0], 16'h2211);
        check("tmo_err_early", err, 0);
        wait_n = 0;
        while (!err && wait_n < 1000) begin
            @(negedge clk);
            wait_n++;
        end
        check("tmo_err", err, 1);
        // err rises 200 cycles after rx_vld; the strobe is 1 cycle after rx_vld
        check("tmo_delay", cyc - wr_cyc, 199);
        $display("timeout: err after %0d cycles from write strobe", cyc - wr_cyc);

        // ---------------- en dropped mid-load ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h11};
        send_tx("en_abort");
        check("en_busy_before", busy, 1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en_busy", busy, 0);
        check("en_err", err, 0);
        check("en_done", done, 0);
        check("en_core_rst_n", core_rst_n, 1);
        en = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- nrst pulsed during a write ----------------
        wr_adr.delete(); wr_dat.delete();
        tx = '{8'hA5, 8'h01, 8'h00, 8'h34};
        send_tx("rst_mid_write");
        fork
            send_byte(8'h12, 1'b1);
            begin
                wait_n = 0;
                while (!pm_bus.pm_ce && wait_n < 400) begin
                    @(negedge clk);
                    wait_n++;
                end
                check("rstw_strobe_seen", pm_bus.pm_ce, 1);
                check("rstw_pre_dout", pm_bus.pm_dout, 16'h1234);
                nrst = 1'b0;
                #1;
                check("rstw_ce", pm_bus.pm_ce, 0);
                check("rstw_we", {pm_bus.pm_we_h, pm_bus.pm_we_l}, 0);
                check("rstw_dout", pm_bus.pm_dout, 0);
                check("rstw_adr", pm_bus.pm_adr, 0);
                check("rstw_core_rst_n", core_rst_n, 0);
                check("rstw_busy", busy, 0);
                check("rstw_done_err", {done, err}, 0);
            end
        join
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("rstw_release_core_rst_n", core_rst_n, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
